// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// A start is accepted when ctrl_DIV is high while data_inputRDY is high;
// the quotient appears 32 edges later with a one-cycle data_resultRDY strobe.
// A zero divisor finishes one edge after the start with data_exception = 1.
// Optional feature: define DIVIDER_SIGNED_EN for two's complement operands
// (magnitude division, quotient negated on differing signs, overflow flag).
// Handshake: the start is accepted at a rising edge where ctrl_DIV=1 and
// data_inputRDY=1; data_resultRDY is high for exactly the cycle in DONE.
module divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_exception,
  output logic             data_inputRDY,
  output logic             data_resultRDY,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [5:0]       count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             neg;
  logic             ovf;
  logic             div_zero;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             neg_in;
  logic             ovf_in;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_final;

  assign state_dbg = state;

  // Operand conditioning at start: magnitudes, result sign and overflow case.
  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    mag_a  = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    mag_b  = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
    neg_in = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
    ovf_in = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
             (data_operandB == {WIDTH{1'b1}});
`else
    mag_a  = data_operandA;
    mag_b  = data_operandB;
    neg_in = 1'b0;
    ovf_in = 1'b0;
`endif
  end

  // One restoring step: shift in the next dividend bit, trial-subtract.
  // The borrow lands in bit WIDTH because the remainder stays below the divisor.
  always_comb begin
    rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff      = rem_shift - {1'b0, divisor};
    q_bit     = ~diff[WIDTH];
    rem_next  = q_bit ? diff : rem_shift;
    quo_next  = {quo[WIDTH-2:0], q_bit};
    quo_final = neg ? (~quo_next + 1'b1) : quo_next;
  end

  // Control FSM with registered outputs and the datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      rem            <= '0;
      quo            <= '0;
      divisor        <= '0;
      neg            <= 1'b0;
      ovf            <= 1'b0;
      div_zero       <= 1'b0;
      data_result    <= '0;
      data_exception <= '0;
      data_inputRDY  <= 1'b1;
      data_resultRDY <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          data_resultRDY <= 1'b0;
          if (ctrl_DIV) begin
            state         <= BUSY;
            data_inputRDY <= 1'b0;
            quo           <= mag_a;
            divisor       <= mag_b;
            rem           <= '0;
            count         <= '0;
            neg           <= neg_in;
            ovf           <= ovf_in;
            div_zero      <= (data_operandB == '0);
          end else begin
            state         <= IDLE;
            data_inputRDY <= 1'b1;
          end
        end
        BUSY: begin
          if (div_zero) begin
            state          <= DONE;
            data_result    <= '0;
            data_exception <= {{(WIDTH-1){1'b0}}, 1'b1};
            data_resultRDY <= 1'b1;
            data_inputRDY  <= 1'b1;
          end else begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + 6'd1;
            if (count == 6'd31) begin
              state          <= DONE;
              data_result    <= quo_final;
              data_exception <= {{(WIDTH-2){1'b0}}, ovf, 1'b0};
              data_resultRDY <= 1'b1;
              data_inputRDY  <= 1'b1;
            end
          end
        end
        default: begin
          state          <= IDLE;
          data_inputRDY  <= 1'b1;
          data_resultRDY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: directed vectors plus randomized operations.
// Expected results come from plain integer division and are queued at
// acceptance; a negedge monitor pops and compares each result strobe,
// including the edge on which it arrives.
module tb_divider_seq;

  localparam int W = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic [31:0] data_exception;
  logic        data_inputRDY;
  logic        data_resultRDY;
  logic [1:0]  state_dbg;

  divider_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_inputRDY  (data_inputRDY),
    .data_resultRDY (data_resultRDY),
    .state_dbg      (state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           errors = 0;
  int           checks = 0;
  logic         prev_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division following the operand rules.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    int q;
    if (b == 32'h0) return {32'h1, 32'h0};
`ifdef DIVIDER_SIGNED_EN
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h2, 32'h80000000};
    sa = a;
    sb = b;
    q  = sa / sb;
    return {32'h0, 32'(q)};
`else
    sa = 0; sb = 0; q = 0;
    return {32'h0, a / b};
`endif
  endfunction

  // Driver: wait for inputRDY, present a start for one edge, queue expectation.
  task automatic start(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expv, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge clock);
    while (!data_inputRDY && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!data_inputRDY) begin
      checks++;
      errors++;
      $display("FAIL start_timeout actual=busy required=inputRDY within 200 cycles");
    end else begin
      data_operandA = a;
      data_operandB = b;
      ctrl_DIV      = 1'b1;
      @(negedge clock);
      ctrl_DIV = 1'b0;
      acc = cyc;
      exp_q.push_back(expv);
      exp_cyc_q.push_back(cyc + ((b == 32'h0) ? 1 : 32));
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    logic [W-1:0] e;
    int           ec;
    if (reset) begin
      prev_rdy = 1'b0;
    end else begin
      if (prev_rdy) check("strobe_one_cycle", data_resultRDY, 1'b0);
      if (data_resultRDY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h required=no strobe (cycle %0d)", data_result, cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result", data_result, e[31:0]);
          check("exception", data_exception, e[63:32]);
          check("result_cycle", cyc, ec);
          check("inputRDY_in_done", data_inputRDY, 1'b1);
        end
      end
      prev_rdy = data_resultRDY;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc1;
    int n;
    logic [31:0] a;
    logic [31:0] b;
    int r;

    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #2;
    check("reset_result", data_result, 0);
    check("reset_exception", data_exception, 0);
    check("reset_resultRDY", data_resultRDY, 0);
    check("reset_inputRDY", data_inputRDY, 1);
    check("reset_state", state_dbg, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_result_zero", data_result, 0);
    check("idle_inputRDY", data_inputRDY, 1);

    // directed vectors
    start(32'd100, 32'd7, {32'h0, 32'd14}, acc);
    start(32'd5, 32'd0, {32'h1, 32'h0}, acc);
    start(32'd0, 32'd5, {32'h0, 32'h0}, acc);
`ifdef DIVIDER_SIGNED_EN
    start(32'hFFFFFF9C, 32'd7, {32'h0, 32'hFFFFFFF2}, acc);
    start(32'h80000000, 32'hFFFFFFFF, {32'h2, 32'h80000000}, acc);
    start(32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, acc);
    start(32'd7, 32'hFFFFFFFE, {32'h0, 32'hFFFFFFFD}, acc);
`else
    start(32'hFFFFFF9C, 32'd7, {32'h0, 32'h24924916}, acc);
    start(32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h0}, acc);
    start(32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, acc);
    start(32'hFFFFFFFF, 32'hFFFFFFFF, {32'h0, 32'h1}, acc);
`endif

    // busy start ignored, then back-to-back start accepted in DONE
    start(32'd100, 32'd7, {32'h0, 32'd14}, acc);
    repeat (9) @(negedge clock);
    check("busy_inputRDY_low", data_inputRDY, 0);
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    start(32'd9, 32'd3, {32'h0, 32'd3}, acc1);
    check("back_to_back_accept", acc1, acc + 33);

    // reset in the middle of an operation
    start(32'd100, 32'd7, {32'h0, 32'd14}, acc);
    repeat (10) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort_result", data_result, 0);
    check("abort_exception", data_exception, 0);
    check("abort_resultRDY", data_resultRDY, 0);
    check("abort_inputRDY", data_inputRDY, 1);
    check("abort_state", state_dbg, 0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) n++;
    end
    check("no_strobe_after_abort", n, 0);

    // start at the first edge after reset release
    #1 reset = 1'b1;
    @(negedge clock);
    reset         = 1'b0;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    exp_q.push_back({32'h0, 32'd14});
    exp_cyc_q.push_back(cyc + 32);
    check("first_edge_accept_busy", data_inputRDY, 0);

    // randomized operations
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      a = (r < 3) ? 32'($urandom_range(0, 1000)) : $urandom;
      if (r == 0)      b = 32'h0;
      else if (r < 5)  b = 32'($urandom_range(1, 15));
      else if (r == 5) b = 32'hFFFFFFFF;
      else             b = $urandom;
      start(a, b, model(a, b), acc);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
